serial_byte_receiver: RTL and testbench

- Bit-serial frame receiver; the receiving end of the team's single-wire serial byte link, where a serializer drives the line.
- Idle-high line; frame = start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1).
- Each bit lasts CLKS_PER_BIT clocks. Sits between the serial pin logic and the byte-wide datapath.

---
 rtl/serial_link_pkg.sv | 17 +
 rtl/serial_byte_receiver_if.sv | 12 +
 rtl/serial_bit_timer.sv | 29 ++
 rtl/serial_byte_receiver.sv | 134 +++++++++++++
 tb/tb_serial_byte_receiver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial byte link (receiver and serializer).
package serial_link_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Byte-side and line-side signals of the serial byte receiver.
interface serial_byte_receiver_if #(
   parameter int DATA_W = 8
);
   logic              in0;
   logic [DATA_W-1:0] out;
   logic              out_valid;
   logic              frame_err;

   modport master (output in0, input out, input out_valid, input frame_err);
   modport slave  (input in0, output out, output out_valid, output frame_err);
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period counter with clear; flags the mid-bit (half) and last (full) clock of a period.
module serial_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic half,
   output logic full
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || count == FULL_M1) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign half = (count == HALF_M1);
   assign full = (count == FULL_M1);
endmodule

// File: rtl/serial_byte_receiver.sv
// Serial frame receiver: start, DATA_W bits LSB first, optional even parity, stop.
// Parity checking is built when SERIAL_RX_PARITY_CHECK_EN is defined.
module serial_byte_receiver #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input logic                   clk,
   input logic                   rst,
   serial_byte_receiver_if.slave bus
);
   import serial_link_pkg::*;

   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_START     = START;
   localparam logic [2:0] ST_DATA      = DATA;
   localparam logic [2:0] ST_PARITY    = PARITY;
   localparam logic [2:0] ST_STOP      = STOP;
   localparam logic [2:0] ST_WAIT_IDLE = WAIT_IDLE;

   logic [2:0]        state;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_next;
   logic [DATA_W-1:0] word;
   logic              valid;
   logic              err;
   logic              tick_half;
   logic              tick_full;
   logic              timer_clear;
`ifdef SERIAL_RX_PARITY_CHECK_EN
   logic              parity_bad;
`endif

   // The timer is re-phased at the start-bit midpoint, so every later full tick is mid-bit.
   assign timer_clear = (state == ST_IDLE) || (state == ST_WAIT_IDLE) ||
                        ((state == ST_START) && tick_half);

   serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(timer_clear),
      .half (tick_half),
      .full (tick_full)
   );

   generate
      if (DATA_W == 1) begin : g_shift_one
         assign shift_next = bus.in0;
      end else begin : g_shift_many
         assign shift_next = {bus.in0, shift_reg[DATA_W-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         word      <= '0;
         valid     <= 1'b0;
         err       <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
         parity_bad <= 1'b0;
`endif
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.in0 == START_BIT) state <= ST_START;
            end
            ST_START: begin
               if (tick_half) begin
                  if (bus.in0 == START_BIT) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (tick_full) begin
                  shift_reg <= shift_next;
                  if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef SERIAL_RX_PARITY_CHECK_EN
            ST_PARITY: begin
               if (tick_full) begin
                  parity_bad <= (^shift_reg) ^ bus.in0;
                  state      <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (tick_full) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
                  if (bus.in0 == STOP_BIT && !parity_bad) begin
`else
                  if (bus.in0 == STOP_BIT) begin
`endif
                     word  <= shift_reg;
                     valid <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
                  // A low stop bit means the line may still be held low; never restart on it.
                  state <= (bus.in0 == STOP_BIT) ? ST_IDLE : ST_WAIT_IDLE;
               end
            end
            ST_WAIT_IDLE: begin
               if (bus.in0 == LINE_IDLE) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.out       = word;
   assign bus.out_valid = valid;
   assign bus.frame_err = err;
endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver (DATA_W=8, CLKS_PER_BIT=4).
module tb_serial_byte_receiver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   int          valid_cnt = 0;
   int          err_cnt = 0;
   int          overlap_cnt = 0;
   int          last_valid_cyc = -1;
   int          last_err_cyc = -1;
   logic [7:0]  last_valid_val = 8'h00;

`ifdef SERIAL_RX_PARITY_CHECK_EN
   localparam int LAT = 43;
`else
   localparam int LAT = 39;
`endif

   serial_byte_receiver_if #(.DATA_W(8)) bus ();

   serial_byte_receiver #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A pulse seen after edge N belongs to the cycle ending at edge N+1.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc + 1;
            last_valid_val <= bus.out;
         end
         if (bus.frame_err === 1'b1) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc + 1;
         end
         if (bus.out_valid === 1'b1 && bus.frame_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
      end
   end

   task automatic idle(input int n);
      bus.in0 = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.in0 = b;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int t0);
      t0 = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_CHECK_EN
      send_bit(par);
`else
      if (par === 1'bx) $display("note: parity argument unknown");
`endif
      send_bit(stop);
   endtask

   task automatic test_reset;
      bus.in0 = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.out !== 8'h00) begin failures++; $display("FAIL reset_out: got %h want 00", bus.out); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_single;
      int t0, v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, t0);
      idle(4);
      checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL single_count: got %0d want %0d", valid_cnt - v0, 1); end
      checks++; if (last_valid_cyc !== t0 + LAT) begin failures++; $display("FAIL single_latency: got %0d want %0d", last_valid_cyc - t0, LAT); end
      checks++; if (bus.out !== 8'hA5) begin failures++; $display("FAIL single_out: got %h want a5", bus.out); end
      checks++; if (err_cnt !== e0) begin failures++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_glitch;
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_bit(1'b1);
      bus.in0 = 1'b0;
      @(posedge clk); #1;
      idle(12);
      checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0); end
      checks++; if (err_cnt !== e0) begin failures++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
      checks++; if (bus.out !== 8'hA5) begin failures++; $display("FAIL glitch_out: got %h want a5", bus.out); end
   endtask

   task automatic test_stop_error;
      int t0, v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, t0);
      bus.in0 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL stoperr_count: got %0d want 1", err_cnt - e0); end
      checks++; if (last_err_cyc !== t0 + LAT) begin failures++; $display("FAIL stoperr_cycle: got %0d want %0d", last_err_cyc - t0, LAT); end
      checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL stoperr_valid: got %0d want 0", valid_cnt - v0); end
      checks++; if (bus.out !== 8'hA5) begin failures++; $display("FAIL stoperr_out: got %h want a5", bus.out); end
      idle(4);
      send_frame(8'h81, 1'b0, 1'b1, t0);
      idle(4);
      checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL recover_count: got %0d want 1", valid_cnt - v0); end
      checks++; if (bus.out !== 8'h81) begin failures++; $display("FAIL recover_out: got %h want 81", bus.out); end
      checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL recover_err: got %0d want 1", err_cnt - e0); end
   endtask

   task automatic test_back_to_back;
      int ta, tb, ca;
      send_frame(8'h00, 1'b0, 1'b1, ta);
      ca = last_valid_cyc;
      checks++; if (last_valid_val !== 8'h00 || ca !== ta + LAT) begin failures++; $display("FAIL b2b_first: got %h@%0d want 00@%0d", last_valid_val, ca - ta, LAT); end
      send_frame(8'hFF, 1'b0, 1'b1, tb);
      idle(4);
      checks++; if (last_valid_val !== 8'hFF) begin failures++; $display("FAIL b2b_second_val: got %h want ff", last_valid_val); end
      checks++; if (last_valid_cyc - ca !== LAT + 1) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", last_valid_cyc - ca, LAT + 1); end
      checks++; if (tb !== ta + LAT + 1) begin failures++; $display("FAIL b2b_start: got %0d want %0d", tb - ta, LAT + 1); end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] d;
      int t0, v0;
      d = 8'h5A;
      v0 = valid_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      bus.in0 = d[4];
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.out !== 8'h00) begin failures++; $display("FAIL midrst_out: got %h want 00", bus.out); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(8);
      checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL midrst_valid: got %0d want 0", valid_cnt - v0); end
      send_frame(d, 1'b0, 1'b1, t0);
      idle(4);
      checks++; if (bus.out !== 8'h5A) begin failures++; $display("FAIL midrst_next_out: got %h want 5a", bus.out); end
      checks++; if (last_valid_cyc !== t0 + LAT) begin failures++; $display("FAIL midrst_next_cycle: got %0d want %0d", last_valid_cyc - t0, LAT); end
   endtask

`ifdef SERIAL_RX_PARITY_CHECK_EN
   task automatic test_parity;
      int t0, v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h07, 1'b1, 1'b1, t0);
      idle(4);
      checks++; if (valid_cnt !== v0 + 1 || last_valid_cyc !== t0 + 43) begin failures++; $display("FAIL parity_good: got %0d@%0d want 1@43", valid_cnt - v0, last_valid_cyc - t0); end
      checks++; if (bus.out !== 8'h07) begin failures++; $display("FAIL parity_good_out: got %h want 07", bus.out); end
      send_frame(8'h07, 1'b0, 1'b1, t0);
      idle(4);
      checks++; if (err_cnt !== e0 + 1 || last_err_cyc !== t0 + 43) begin failures++; $display("FAIL parity_bad: got %0d@%0d want 1@43", err_cnt - e0, last_err_cyc - t0); end
      checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL parity_bad_valid: got %0d want 1", valid_cnt - v0); end
   endtask
`endif

   initial begin
      bus.in0 = 1'b1;
      test_reset();
      test_single();
      test_glitch();
      test_stop_error();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_CHECK_EN
      test_parity();
`endif
      checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
